// File: rtl/vvm_requant_pkg.sv
// vvm_requant_pkg: widths, stage payload structs and requant arithmetic helpers
package vvm_requant_pkg;

    localparam int DQ  = 18;
    localparam int Q   = 8;
    localparam int BW  = 24;
    localparam int MW  = 16;
    localparam int SHW = 5;
    localparam int CW  = 16;
    localparam int SW  = ((DQ > BW) ? DQ : BW) + 1;
    localparam int PW  = SW + MW + 1;

    localparam logic signed [Q-1:0] QMAX = {1'b0, {(Q-1){1'b1}}};
    localparam logic signed [Q-1:0] QMIN = {1'b1, {(Q-1){1'b0}}};

    typedef struct packed {
        logic signed [SW-1:0] s;
        logic [MW-1:0]        m;
        logic [SHW-1:0]       sh;
        logic signed [Q-1:0]  z;
        logic                 relu;
    } s1_t;

    typedef struct packed {
        logic signed [PW-1:0] p;
        logic [SHW-1:0]       sh;
        logic signed [Q-1:0]  z;
        logic                 relu;
    } s2_t;

    // Arithmetic right shift with round-half-up toward +inf
    function automatic logic signed [PW-1:0] rshift_round(logic signed [PW-1:0] p, logic [SHW-1:0] sh);
        logic signed [PW-1:0] half;
        half = (sh == '0) ? '0 : (PW'(1) << (sh - SHW'(1)));
        return (p + half) >>> sh;
    endfunction

    // Clamp v into [lo, QMAX]; the flag reports only true int range overflow
    function automatic logic [Q:0] sat_q(logic signed [PW:0] v, logic signed [Q-1:0] lo);
        logic signed [PW:0] hi_x, min_x, lo_x;
        hi_x  = (PW+1)'(QMAX);
        min_x = (PW+1)'(QMIN);
        lo_x  = (PW+1)'(lo);
        return {(v > hi_x) || (v < min_x), (v > hi_x) ? QMAX : (v < lo_x) ? lo : v[Q-1:0]};
    endfunction

endpackage

// File: rtl/vvm_requant_if.sv
// vvm_requant_if: accumulator input stream and requantized output stream
interface vvm_requant_if;
    import vvm_requant_pkg::*;

    logic signed [DQ-1:0] acc_in;
    logic signed [BW-1:0] bias;
    logic [MW-1:0]        m_scale;
    logic [SHW-1:0]       shift;
    logic signed [Q-1:0]  z_out;
    logic                 relu_en;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [Q-1:0]  q_out;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output acc_in, bias, m_scale, shift, z_out, relu_en, in_valid, out_ready,
        input  in_ready, q_out, out_valid
    );

    modport slave (
        input  acc_in, bias, m_scale, shift, z_out, relu_en, in_valid, out_ready,
        output in_ready, q_out, out_valid
    );

endinterface

// File: rtl/vvm_requant_stage_reg.sv
// vvm_requant_stage_reg: one pipeline stage, valid flop plus payload flop sharing an enable
module vvm_requant_stage_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Load valid and payload together whenever the pipe advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/vvm_requant.sv
// vvm_requant: 3-stage bias/scale/shift/zero-point/clamp requantizer with saturation counter
module vvm_requant
    import vvm_requant_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    vvm_requant_if.slave  bus,
    input  logic          sat_clr,
    output logic [CW-1:0] sat_cnt
);

    logic                adv;
    logic                v1, v2, v3;
    s1_t                 s1_d, s1_q;
    s2_t                 s2_d, s2_q;
    logic signed [PW:0]  t;
    logic signed [Q-1:0] lo;
    logic                sat_d;
    logic [Q-1:0]        q3_d, q3_q;
    logic [CW-1:0]       cnt_d, cnt_q;

    // A single advance signal keeps every stage in lockstep; only a full, unaccepted output stalls
    assign adv          = !v3 || bus.out_ready;
    assign bus.in_ready = adv;

    // Stage 1 bias add and stage 2 scale multiply, config travels alongside
    always_comb begin
        s1_d.s    = SW'(bus.acc_in) + SW'(bus.bias);
        s1_d.m    = bus.m_scale;
        s1_d.sh   = bus.shift;
        s1_d.z    = bus.z_out;
        s1_d.relu = bus.relu_en;
        s2_d.p    = PW'(s1_q.s) * PW'($signed({1'b0, s1_q.m}));
        s2_d.sh   = s1_q.sh;
        s2_d.z    = s1_q.z;
        s2_d.relu = s1_q.relu;
    end

    // Stage 3 rounding shift, zero-point add and clamp; ReLU only raises the floor
    always_comb begin
        t             = (PW+1)'(rshift_round(s2_q.p, s2_q.sh)) + (PW+1)'(s2_q.z);
        lo            = s2_q.relu ? s2_q.z : QMIN;
        {sat_d, q3_d} = sat_q(t, lo);
        cnt_d         = sat_clr ? '0 : (v2 && adv && sat_d && cnt_q != '1) ? cnt_q + CW'(1) : cnt_q;
    end

    vvm_requant_stage_reg #(.W($bits(s1_t))) u_s1 (
        .clk(clk), .rst_n(rst_n), .en_i(adv), .valid_i(bus.in_valid),
        .data_i(s1_d), .valid_o(v1), .data_o(s1_q)
    );

    vvm_requant_stage_reg #(.W($bits(s2_t))) u_s2 (
        .clk(clk), .rst_n(rst_n), .en_i(adv), .valid_i(v1),
        .data_i(s2_d), .valid_o(v2), .data_o(s2_q)
    );

    vvm_requant_stage_reg #(.W(Q)) u_s3 (
        .clk(clk), .rst_n(rst_n), .en_i(adv), .valid_i(v2),
        .data_i(q3_d), .valid_o(v3), .data_o(q3_q)
    );

    // Saturation event counter, sticky at full scale, clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign bus.q_out     = q3_q;
    assign bus.out_valid = v3;
    assign sat_cnt       = cnt_q;

endmodule
